clkdiv_multi: RTL and testbench
===============================

CLKDIV_MULTI -- requirements
Module: clkdiv_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter CW, default 32: divisor and counter width in bits.
REQ-003 Port clk  input  1: system clock, crystal oscillator 100 MHz; the only clock.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port en  input  NCH: per-channel count enable, bit i controls channel i.
REQ-006 Port mode  input  NCH: per-channel output mode; 0 = toggle (square wave), 1 = strobe (one-cycle pulse).
REQ-007 Port div  input  NCH*CW: per-channel divisor N; channel i uses bits [i*CW +: CW].
REQ-008 Port load  input  NCH: per-channel one-cycle request to capture div into that channel's pending register.
REQ-009 Port sync  input  1: one-cycle request to restart all channels phase-aligned.
REQ-010 Port clk_out  output  NCH: registered divided clock, toggle mode.
REQ-011 Port strobe  output  NCH: registered terminal-count pulse, strobe mode.
REQ-012 Port pend  output  NCH: high while a loaded divisor awaits application.

Function
REQ-013 Each channel SHALL hold a counter cnt (CW bits), an active divisor act (CW bits), a pending divisor pdiv (CW bits) and a pending flag.
REQ-014 Effective divisor SHALL be act, with act = 0 treated as 1.
REQ-015 Enabled cycle, cnt >= effective divisor - 1 (terminal): cnt <= 0; terminal event occurs.
REQ-016 Enabled cycle, not terminal: cnt <= cnt + 1; no wrap possible since terminal uses >=.
REQ-017 Terminal event, mode 0: clk_out[i] toggles; output period = 2N cycles, 50% duty; strobe[i] stays 0.
REQ-018 Terminal event, mode 1: strobe[i] = 1 for exactly the next cycle; clk_out[i] holds; strobe period = N cycles; N = 1 gives strobe continuously high.
REQ-019 en[i] low: cnt, clk_out[i] held; strobe[i] = 0.
REQ-020 load[i] high: pdiv <= div slice, pend[i] <= 1 on the next edge; a second load before application overwrites pdiv.
REQ-021 Pending divisor SHALL be applied (act <= pdiv, pend <= 0) at the edge of the next terminal event, never mid-period, so no runt output pulse occurs.
REQ-022 Pending divisor SHALL be applied on the next edge if en[i] is low.
REQ-023 load[i] on the same cycle as a terminal event: the new div value SHALL be applied at that edge directly (pend stays 0).
REQ-024 sync high: all channels cnt <= 0, clk_out <= 0, strobe <= 0; any pending divisor applied, and a coincident load applied directly; pend <= 0. sync overrides en and terminal events.
REQ-025 mode change SHALL take effect at the next edge without altering cnt; clk_out holds its level in mode 1.
REQ-026 Channels SHALL be fully independent except via sync.

Reset
REQ-027 rst_n low SHALL asynchronously force cnt = 0, act = 0 (divide-by-1), pdiv = 0, pend = 0, clk_out = 0, strobe = 0 for all channels.
REQ-028 Counting SHALL resume on the first clk edge after rst_n deasserts; reset mid-period discards all state including pending loads.

Verification
REQ-029 rst, load ch0 div=5, en=1, mode 0 -> clk_out[0] toggles every 5 cycles (period 10, 5 high / 5 low).
REQ-030 mode 1, div=3 -> strobe high 1 cycle in every 3; div=1 -> strobe constantly high; div=0 -> same as div=1.
REQ-031 div=8 running, load div=2 at cnt=3 -> pend=1 until cnt reaches 7, then period becomes 4 with no short pulse; pend=0.
REQ-032 ch0 div=4, ch1 div=6 free-running, sync pulse -> both clk_out low, cnt 0 next cycle; ch0 toggles 4 cycles later, ch1 6 cycles later.
REQ-033 en[2] low for 7 cycles mid-period at cnt=2 -> clk_out[2] and cnt frozen, resume from cnt=3; load while disabled applies next edge.
REQ-034 rst_n asserted asynchronously between edges with clk_out=1 -> clk_out=0 immediately; after release divisor is 1.

Source files
------------

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: each channel produces either a
// 50% square wave (period 2N) or a one-cycle strobe every N cycles.
module clkdiv_multi #(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    mode,
  input  logic [NCH*CW-1:0] div,
  input  logic [NCH-1:0]    load,
  input  logic              sync,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    strobe,
  output logic [NCH-1:0]    pend
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] act;
    logic [CW-1:0] pdiv;
    logic [CW-1:0] div_i;
    logic [CW-1:0] eff;
    logic          term;
    logic          co_q;
    logic          st_q;
    logic          pd_q;

    // A zero divisor behaves as divide-by-1 so the counter can never stall.
    assign div_i = div[g*CW +: CW];
    assign eff   = (act == '0) ? CW'(1) : act;
    assign term  = en[g] && (cnt >= eff - CW'(1));

    // NOTE: every register here is updated with <= so all channel state
    // changes together at the edge; these are flops, not RAM, so each one
    // takes the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt  <= '0;
        act  <= '0;
        pdiv <= '0;
        pd_q <= 1'b0;
        co_q <= 1'b0;
        st_q <= 1'b0;
      end else if (sync) begin
        cnt  <= '0;
        co_q <= 1'b0;
        st_q <= 1'b0;
        pd_q <= 1'b0;
        if (load[g]) begin
          act  <= div_i;
          pdiv <= div_i;
        end else if (pd_q) begin
          act <= pdiv;
        end
      end else begin
        st_q <= term && mode[g];
        if (term) begin
          cnt <= '0;
          if (!mode[g]) co_q <= ~co_q;
        end else if (en[g]) begin
          cnt <= cnt + CW'(1);
        end

        // New divisors only take effect on a period boundary (or while idle),
        // which is what keeps the output free of runt pulses.
        if (load[g] && term) begin
          act  <= div_i;
          pdiv <= div_i;
          pd_q <= 1'b0;
        end else if (load[g]) begin
          pdiv <= div_i;
          pd_q <= 1'b1;
        end else if (pd_q && (term || !en[g])) begin
          act  <= pdiv;
          pd_q <= 1'b0;
        end
      end
    end

    assign clk_out[g] = co_q;
    assign strobe[g]  = st_q;
    assign pend[g]    = pd_q;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: stimulus pushes predicted outputs from a
// behavioural channel model, a monitor pops and compares after every edge.
module tb_clkdiv_multi;
  localparam int NCH = 4;
  localparam int CW  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    en = '0;
  logic [NCH-1:0]    mode = '0;
  logic [NCH*CW-1:0] div = '0;
  logic [NCH-1:0]    load = '0;
  logic              sync = 1'b0;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    strobe;
  logic [NCH-1:0]    pend;

  clkdiv_multi #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div),
    .load(load), .sync(sync), .clk_out(clk_out), .strobe(strobe), .pend(pend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per channel, the position within the current period,
  // the divisor in force, and a pending divisor waiting for a period boundary.
  int unsigned m_pos [NCH];
  int unsigned m_n   [NCH];
  int unsigned m_next[NCH];
  bit          m_has_next[NCH];
  logic [NCH-1:0] m_co, m_st;

  logic [NCH-1:0]    en_v = '0;
  logic [NCH-1:0]    mode_v = '0;
  logic [NCH*CW-1:0] div_v = '0;

  logic [3*NCH-1:0] exp_q[$];

  function automatic logic [3*NCH-1:0] model_outputs();
    logic [NCH-1:0] p;
    for (int i = 0; i < NCH; i++) p[i] = m_has_next[i];
    return {m_co, m_st, p};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = 0; m_n[i] = 0; m_next[i] = 0; m_has_next[i] = 0;
    end
    m_co = '0; m_st = '0;
  endtask

  task automatic model_step(input logic [NCH-1:0] ld, input logic sy);
    for (int i = 0; i < NCH; i++) begin
      int unsigned period;
      int unsigned newd;
      bit wrap;
      period = (m_n[i] == 0) ? 1 : m_n[i];
      newd   = div_v[i*CW +: CW];
      wrap   = en_v[i] && (m_pos[i] + 1 >= period);
      if (sy) begin
        m_pos[i] = 0; m_co[i] = 0; m_st[i] = 0;
        if (ld[i]) m_n[i] = newd;
        else if (m_has_next[i]) m_n[i] = m_next[i];
        m_has_next[i] = 0;
      end else begin
        m_st[i] = wrap && mode_v[i];
        if (wrap) begin
          m_pos[i] = 0;
          if (!mode_v[i]) m_co[i] = !m_co[i];
        end else if (en_v[i]) begin
          m_pos[i] = m_pos[i] + 1;
        end
        if (ld[i] && wrap) begin
          m_n[i] = newd; m_has_next[i] = 0;
        end else if (ld[i]) begin
          m_next[i] = newd; m_has_next[i] = 1;
        end else if (m_has_next[i] && (wrap || !en_v[i])) begin
          m_n[i] = m_next[i]; m_has_next[i] = 0;
        end
      end
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, predict the next edge.
  task automatic cyc(input logic r, input logic [NCH-1:0] ld, input logic sy);
    @(negedge clk);
    rst_n = r; en = en_v; mode = mode_v; div = div_v; load = ld; sync = sy;
    if (!r) model_reset();
    else    model_step(ld, sy);
    exp_q.push_back(model_outputs());
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, '0, 1'b0);
  endtask

  task automatic load_ch(input int ch, input int unsigned val);
    div_v[ch*CW +: CW] = val;
    cyc(1'b1, NCH'(1) << ch, 1'b0);
  endtask

  // Monitor: every output update is compared against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [3*NCH-1:0] e;
        e = exp_q.pop_front();
        check("clk_out", 64'(clk_out), 64'(e[3*NCH-1 -: NCH]));
        check("strobe",  64'(strobe),  64'(e[2*NCH-1 -: NCH]));
        check("pend",    64'(pend),    64'(e[NCH-1:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1;
    check("reset_clk_out", 64'(clk_out), 64'(0));
    check("reset_pend", 64'(pend), 64'(0));
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);

    // Square wave on ch0 with divisor 5.
    en_v = '1; mode_v = '0;
    load_ch(0, 5);
    run(25);

    // Strobe mode with divisors 3, 1 and 0.
    mode_v[0] = 1'b1;
    load_ch(0, 3);
    run(10);
    load_ch(0, 1);
    run(5);
    load_ch(0, 0);
    run(5);

    // Divisor change mid-period only lands on the period boundary.
    mode_v[0] = 1'b0;
    load_ch(0, 8);
    run(12);
    load_ch(0, 2);
    run(16);

    // Phase-aligned restart of two channels with different divisors.
    load_ch(0, 4);
    load_ch(1, 6);
    run(9);
    cyc(1'b1, '0, 1'b1);
    run(14);

    // Freeze ch2 mid-period, load while frozen, then resume.
    load_ch(2, 8);
    run(10);
    en_v[2] = 1'b0;
    run(3);
    load_ch(2, 3);
    run(3);
    en_v[2] = 1'b1;
    run(10);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] ld;
      logic sy;
      ld = '0;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 19) == 0) en_v[i] = ~en_v[i];
        if ($urandom_range(0, 39) == 0) mode_v[i] = ~mode_v[i];
        div_v[i*CW +: CW] = $urandom_range(0, 9);
        ld[i] = ($urandom_range(0, 14) == 0);
      end
      sy = ($urandom_range(0, 99) == 0);
      cyc(1'b1, ld, sy);
    end

    // Asynchronous reset between edges while clk_out[0] is high.
    en_v = '1; mode_v = '0;
    load_ch(0, 3);
    for (int k = 0; k < 40 && !m_co[0]; k++) run(1);
    check("async_setup_clk_out0", 64'(m_co[0]), 64'(1));
    @(negedge clk);
    en = en_v; mode = mode_v; div = div_v; load = '0; sync = 1'b0;
    model_reset();
    exp_q.push_back(model_outputs());
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_out", 64'(clk_out), 64'(0));
    check("async_pend", 64'(pend), 64'(0));
    run(12);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
